// File: rtl/fetch_queue_pkg.sv
// Shared constants and the entry layout for the IF->ID fetch queue.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH   = 4;
    localparam int unsigned FQ_AW      = 2;
    localparam int unsigned FQ_ENTRY_W = 96;

    // Bit offsets of each 32-bit field inside a stored entry.
    localparam int unsigned FQ_PC   = 64;
    localparam int unsigned FQ_PCP4 = 32;
    localparam int unsigned FQ_INST = 0;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // One captured fetch; field order matches the offsets above.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_p4;
        logic [31:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: register array, clearing synchronous write port, async read port.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned AW    = FQ_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [FQ_ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [FQ_ENTRY_W-1:0] rdata_o
);

    logic [FQ_ENTRY_W-1:0] mem_q [DEPTH];

    // Storage write; reset clears every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between IF and ID with PC-advance enable and branch squash.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned AW    = FQ_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   if_pc,
    input  logic [31:0]   if_pc_p4,
    input  logic [31:0]   if_inst,
    input  logic          if_stall,
    output logic          if_ce,
    input  logic          flush,
    input  logic          id_ready,
    output logic          id_valid,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_pc_p4,
    output logic [31:0]   id_inst,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    fq_entry_t             wentry_c;
    logic [FQ_ENTRY_W-1:0] rdata_c;

    // Occupancy flags and handshakes; if_ce never looks at id_ready.
    always_comb begin
        full_c  = (count_q == CW'(DEPTH));
        empty_c = (count_q == '0);
        push_c  = ~flush & ~if_stall & ~full_c;
        pop_c   = ~empty_c & id_ready;
        if_ce   = flush | (~if_stall & ~full_c);
    end

    // Pointer and occupancy next state; flush squashes everything.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push_c) wp_d = wp_q + AW'(1);
            if (pop_c)  rp_d = rp_q + AW'(1);
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Pack the incoming fetch into a storage entry.
    always_comb begin
        wentry_c.pc    = if_pc;
        wentry_c.pc_p4 = if_pc_p4;
        wentry_c.inst  = if_inst;
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push_c),
        .waddr_i (wp_q),
        .wdata_i (wentry_c),
        .raddr_i (rp_q),
        .rdata_o (rdata_c)
    );

    // Head presentation; an empty queue shows a NOP at PC 0.
    always_comb begin
        id_valid = ~empty_c;
        id_pc    = empty_c ? 32'h0    : rdata_c[FQ_PC   +: 32];
        id_pc_p4 = empty_c ? 32'h0    : rdata_c[FQ_PCP4 +: 32];
        id_inst  = empty_c ? NOP_INST : rdata_c[FQ_INST +: 32];
        count    = count_q;
    end

endmodule
